// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The checksum helper is the only arithmetic that runs on the stream bytes.
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam int HDR_MAX_WORDS = 255;
    localparam int CSUM_W        = 8;

    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] sum,
                                                   input logic [7:0]        data);
        return sum + data;
    endfunction

    function automatic logic takes_byte(input state_t s);
        case (s)
            S_COUNT, S_HI, S_LO, S_CSUM: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/program_loader.sv
// Loads one COUNT/words/CSUM frame from a byte stream into instruction memory
// and releases the CPU only when the trailing checksum matches.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [DW-1:0] im_din,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam int         RW      = $clog2(HDR_MAX_WORDS + 1);
    localparam logic [8:0] MAX_N_C = 9'(1 << AW);

    state_t            state_r;
    state_t            state_nx_s;
    logic [CSUM_W-1:0] sum_r;
    logic [AW:0]       addr_r;
    logic [RW-1:0]     remaining_r;
    logic [6:0]        hi_r;
    logic              accept_s;

    assign accept_s = in_valid && in_ready;

    // Next-state decode; a set address MSB before a write can only mean corruption.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_COUNT: begin
                if (!accept_s) begin
                    state_nx_s = S_COUNT;
                end else if (in_data == 8'd0) begin
                    state_nx_s = S_CSUM;
                end else if ({1'b0, in_data} > MAX_N_C) begin
                    state_nx_s = S_ERR;
                end else begin
                    state_nx_s = S_HI;
                end
            end
            S_HI: begin
                if (!accept_s) begin
                    state_nx_s = S_HI;
                end else if (in_data[7]) begin
                    state_nx_s = S_ERR;
                end else begin
                    state_nx_s = S_LO;
                end
            end
            S_LO: begin
                if (!accept_s) begin
                    state_nx_s = S_LO;
                end else if (addr_r[AW]) begin
                    state_nx_s = S_ERR;
                end else begin
                    state_nx_s = S_WRITE;
                end
            end
            S_WRITE: begin
                if (remaining_r == RW'(1)) begin
                    state_nx_s = S_CSUM;
                end else begin
                    state_nx_s = S_HI;
                end
            end
            S_CSUM: begin
                if (!accept_s) begin
                    state_nx_s = S_CSUM;
                end else if (in_data == sum_r) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_ERR;
                end
            end
            S_DONE:  state_nx_s = S_DONE;
            S_ERR:   state_nx_s = S_ERR;
            default: state_nx_s = S_ERR;
        endcase
    end

    // State, datapath and outputs; outputs are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_COUNT;
            sum_r       <= '0;
            addr_r      <= '0;
            remaining_r <= '0;
            hi_r        <= 7'd0;
            in_ready    <= 1'b1;
            cpu_hold    <= 1'b1;
            im_we       <= 1'b0;
            im_addr     <= '0;
            im_din      <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            in_ready <= takes_byte(state_nx_s);
            cpu_hold <= (state_nx_s != S_DONE);
            im_we    <= (state_nx_s == S_WRITE);
            done     <= done || (state_nx_s == S_DONE);
            err      <= err || (state_nx_s == S_ERR);
            case (state_r)
                S_COUNT: begin
                    if (accept_s) begin
                        remaining_r <= RW'(in_data);
                        sum_r       <= in_data;
                        addr_r      <= '0;
                    end
                end
                S_HI: begin
                    if (accept_s) begin
                        hi_r  <= in_data[6:0];
                        sum_r <= csum_add(sum_r, in_data);
                    end
                end
                S_LO: begin
                    if (accept_s) begin
                        sum_r   <= csum_add(sum_r, in_data);
                        im_addr <= addr_r[AW-1:0];
                        im_din  <= DW'({hi_r, in_data});
                    end
                end
                S_WRITE: begin
                    addr_r      <= addr_r + (AW+1)'(1);
                    remaining_r <= remaining_r - RW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Drives one byte stream into an AW=8 and an AW=4 loader side by side and
// checks handshakes, memory writes and final status against hand-computed frames.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        rdy8, we8, hold8, done8, err8;
    logic [7:0]  addr8;
    logic [14:0] din8;
    logic        rdy4, we4, hold4, done4, err4;
    logic [3:0]  addr4;
    logic [14:0] din4;

    program_loader #(.AW(8), .DW(15)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy8), .im_we(we8), .im_addr(addr8), .im_din(din8),
        .cpu_hold(hold8), .done(done8), .err(err8)
    );

    program_loader #(.AW(4), .DW(15)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy4), .im_we(we4), .im_addr(addr4), .im_din(din4),
        .cpu_hold(hold4), .done(done4), .err(err4)
    );

    always #5 clk = ~clk;

    // Memory models and cumulative write/accept counters
    logic [14:0] mem8 [256];
    logic [14:0] mem4 [16];
    int wr8 = 0, wr4 = 0, acc8 = 0, acc4 = 0, dbl = 0;
    int last8 = 0, last4 = 0;
    logic pw8 = 1'b0, pw4 = 1'b0;

    always @(posedge clk) begin
        if (we8 === 1'b1) begin
            mem8[addr8] <= din8;
            wr8   <= wr8 + 1;
            last8 <= int'(addr8);
        end
        if (we4 === 1'b1) begin
            mem4[addr4] <= din4;
            wr4   <= wr4 + 1;
            last4 <= int'(addr4);
        end
        if ((we8 === 1'b1 && pw8) || (we4 === 1'b1 && pw4)) dbl <= dbl + 1;
        pw8 <= (we8 === 1'b1);
        pw4 <= (we4 === 1'b1);
        if (in_valid && rdy8 === 1'b1) acc8 <= acc8 + 1;
        if (in_valid && rdy4 === 1'b1) acc4 <= acc4 + 1;
    end

    int total = 0, passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        int          frame;
        bit          gaps;
        bit          done8, err8;
        int          wr8, acc8, last8;
        bit          done4, err4;
        int          wr4, acc4, last4;
        logic [14:0] m0, mlast;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] frame_q [$];
    int b_wr8, b_wr4, b_acc8, b_acc4;

    task automatic build_frame(input int id);
        logic [7:0] s;
        frame_q.delete();
        case (id)
            0: frame_q = '{8'h02, 8'h12, 8'h34, 8'h05, 8'h06, 8'h53};
            1: frame_q = '{8'h02, 8'h12, 8'h34, 8'h05, 8'h06, 8'h54};
            2: frame_q = '{8'h01, 8'h80, 8'h00, 8'h81};
            4: frame_q = '{8'h00, 8'h00};
            5, 6: begin
                s = (id == 5) ? 8'h10 : 8'h11;
                frame_q.push_back(s);
                for (int i = 0; i < int'(frame_q[0]); i++) begin
                    frame_q.push_back(8'(i));
                    frame_q.push_back(8'hA0 + 8'(i));
                    s = s + 8'(i) + 8'hA0 + 8'(i);
                end
                frame_q.push_back(s);
            end
            default: frame_q = '{8'h00, 8'h00};
        endcase
    endtask

    // Present a byte at a negedge; returns with ok=0 if it is never accepted.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int w = 0; w < 8; w++) begin
            if (rdy8 === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk({tag, "_rst8"}, {rdy8, hold8, we8, done8, err8, addr8, din8}, {5'b11000, 23'd0});
        chk({tag, "_rst4"}, {rdy4, hold4, we4, done4, err4, addr4, din4}, {5'b11000, 19'd0});
        @(negedge clk);
        reset = 1'b0;
        b_wr8 = wr8; b_wr4 = wr4; b_acc8 = acc8; b_acc4 = acc4;
    endtask

    initial begin
        bit    ok;
        string t;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0] = '{0, 1'b0, 1'b1, 1'b0, 2, 6, 1, 1'b1, 1'b0, 2, 6, 1, 15'h1234, 15'h0506};
        vecs[1] = '{1, 1'b0, 1'b0, 1'b1, 2, 6, 1, 1'b0, 1'b1, 2, 6, 1, 15'h1234, 15'h0506};
        vecs[2] = '{2, 1'b0, 1'b0, 1'b1, 0, 2, 0, 1'b0, 1'b1, 0, 2, 0, 15'h0000, 15'h0000};
        vecs[3] = '{0, 1'b1, 1'b1, 1'b0, 2, 6, 1, 1'b1, 1'b0, 2, 6, 1, 15'h1234, 15'h0506};
        vecs[4] = '{4, 1'b0, 1'b1, 1'b0, 0, 2, 0, 1'b1, 1'b0, 0, 2, 0, 15'h0000, 15'h0000};
        vecs[5] = '{5, 1'b0, 1'b1, 1'b0, 16, 34, 15, 1'b1, 1'b0, 16, 34, 15, 15'h00A0, 15'h0FAF};
        vecs[6] = '{6, 1'b0, 1'b1, 1'b0, 17, 36, 16, 1'b0, 1'b1, 0, 1, 0, 15'h00A0, 15'h10B0};

        for (int i = 0; i < 7; i++) begin
            t = $sformatf("v%0d", i);
            do_reset(t);
            build_frame(vecs[i].frame);
            foreach (frame_q[k]) begin
                if (vecs[i].gaps) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                send_byte(frame_q[k], ok);
                if (!ok) break;
            end
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            chk({t, "_done8"}, done8, vecs[i].done8);
            chk({t, "_err8"},  err8,  vecs[i].err8);
            chk({t, "_hold8"}, hold8, !vecs[i].done8);
            chk({t, "_rdy8"},  rdy8,  1'b0);
            chk({t, "_wr8"},   wr8 - b_wr8,   vecs[i].wr8);
            chk({t, "_acc8"},  acc8 - b_acc8, vecs[i].acc8);
            chk({t, "_done4"}, done4, vecs[i].done4);
            chk({t, "_err4"},  err4,  vecs[i].err4);
            chk({t, "_hold4"}, hold4, !vecs[i].done4);
            chk({t, "_wr4"},   wr4 - b_wr4,   vecs[i].wr4);
            chk({t, "_acc4"},  acc4 - b_acc4, vecs[i].acc4);
            if (vecs[i].wr8 > 0) begin
                chk({t, "_last8"}, last8, vecs[i].last8);
                chk({t, "_m8_0"},  mem8[0], vecs[i].m0);
                chk({t, "_m8_n"},  mem8[vecs[i].last8], vecs[i].mlast);
            end
            if (vecs[i].wr4 > 0) begin
                chk({t, "_last4"}, last4, vecs[i].last4);
                chk({t, "_m4_0"},  mem4[0], vecs[i].m0);
                chk({t, "_m4_n"},  mem4[vecs[i].last4], vecs[i].mlast);
            end
        end

        // Reset asserted while the first word is being written
        do_reset("mid");
        send_byte(8'h02, ok);
        send_byte(8'h12, ok);
        send_byte(8'h34, ok);
        chk("mid_we_before", {we8, addr8, din8}, {1'b1, 8'h00, 15'h1234});
        #1 reset = 1'b1;
        #1;
        chk("mid_rst8", {rdy8, hold8, we8, done8, err8, addr8, din8}, {5'b11000, 23'd0});
        @(negedge clk);
        reset = 1'b0;
        b_wr8 = wr8;
        send_byte(8'h01, ok);
        send_byte(8'h7F, ok);
        send_byte(8'hFF, ok);
        send_byte(8'h7F, ok);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_done8", {done8, err8, hold8}, 3'b100);
        chk("mid_wr8",   wr8 - b_wr8, 1);
        chk("mid_m8_0",  mem8[0], 15'h7FFF);
        chk("we_back_to_back", dbl, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
